// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package imem_pkg;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } imem_state_e;

  localparam int unsigned NOP_DEFAULT_W = 8;
  localparam logic [NOP_DEFAULT_W-1:0] NOP_DEFAULT = 8'h00;

  // Index width for a DEPTH-entry array; never below one bit.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one registered read port.
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned         ADDR_W    = 8,
  parameter int unsigned         INSTR_W   = 8,
  parameter int unsigned         DEPTH     = 256,
  parameter logic [INSTR_W-1:0]  NOP_VALUE = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [INSTR_W-1:0] wr_data_i,
  input  logic               rd_en_i,
  input  logic               rd_oob_i,
  input  logic [ADDR_W-1:0]  rd_addr_i,
  output logic [INSTR_W-1:0] rd_data_o
);

  localparam int unsigned IDX_W = idx_width(DEPTH);

  // Contents power up as NOP and are deliberately untouched by reset.
  logic [INSTR_W-1:0] mem_q [DEPTH] = '{default: NOP_VALUE};
  logic [INSTR_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[IDX_W'(wr_addr_i)] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= NOP_VALUE;
    end else if (rd_en_i) begin
      rd_data_q <= rd_oob_i ? NOP_VALUE : mem_q[IDX_W'(rd_addr_i)];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/imem_loadable.sv
// Registered-read instruction memory with a streaming program-load port.
// Optional fetch bounds fault reporting under IMEM_BOUNDS_CHECK_EN.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 8,
  parameter int unsigned        INSTR_W   = 8,
  parameter int unsigned        DEPTH     = 256,
  parameter logic [INSTR_W-1:0] NOP_VALUE = INSTR_W'(NOP_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_req,
  input  logic [ADDR_W-1:0]          fetch_addr,
  output logic                       fetch_ready,
  output logic                       instr_valid,
  output logic [INSTR_W-1:0]         instruction,
  output logic [ADDR_W-1:0]          instr_addr,
  input  logic                       load_start,
  input  logic                       load_valid,
  input  logic [INSTR_W-1:0]         load_data,
  input  logic                       load_last,
  output logic                       loading,
  output logic [$clog2(DEPTH+1)-1:0] load_count,
  output logic                       instr_fault,
  output logic                       fault_sticky
);

  localparam int unsigned IDX_W = idx_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  imem_state_e        state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_en;
  logic               accept;
  logic               oob;
  logic               valid_q;
  logic [ADDR_W-1:0]  addr_q;

  // A load request in the same cycle always beats a fetch.
  assign fetch_ready = (state_q == ST_RUN) && !load_start;
  assign accept      = fetch_req && fetch_ready;
  assign oob         = {1'b0, fetch_addr} >= (ADDR_W+1)'(DEPTH);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    if (load_start) begin
      state_d = ST_LOAD;
      ptr_d   = '0;
      cnt_d   = '0;
    end else if (state_q == ST_LOAD && load_valid) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + IDX_W'(1);
      cnt_d = cnt_q + CNT_W'(1);
      if (load_last || ptr_q == IDX_W'(DEPTH - 1)) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      ptr_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      valid_q <= accept;
      if (accept) begin
        addr_q <= fetch_addr;
      end
    end
  end

  imem_array #(
    .ADDR_W    (ADDR_W),
    .INSTR_W   (INSTR_W),
    .DEPTH     (DEPTH),
    .NOP_VALUE (NOP_VALUE)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_addr_i (ADDR_W'(ptr_q)),
    .wr_data_i (load_data),
    .rd_en_i   (accept),
    .rd_oob_i  (oob),
    .rd_addr_i (fetch_addr),
    .rd_data_o (instruction)
  );

  assign instr_valid = valid_q;
  assign instr_addr  = addr_q;
  assign loading     = (state_q == ST_LOAD);
  assign load_count  = cnt_q;

`ifdef IMEM_BOUNDS_CHECK_EN
  logic fault_q;
  logic sticky_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      fault_q  <= accept && oob;
      sticky_q <= sticky_q || (accept && oob);
    end
  end

  assign instr_fault  = fault_q;
  assign fault_sticky = sticky_q;
`else
  assign instr_fault  = 1'b0;
  assign fault_sticky = 1'b0;
`endif

endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, synchronous instruction memory for the CPU core. It replaces the fixed 8-bit combinational instruction ROM with a registered-read fetch port that uses a ready/valid handshake. It also adds a sequential program-load port, so a bench or boot loader can stream a program in at run time. It sits between the program-counter logic and the decode stage.

## Interface
Parameters:
- ADDR_W, 8, fetch address width.
- INSTR_W, 8, instruction word width.
- DEPTH, 256, number of words; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W.
- NOP_VALUE, all zeros, word returned for unwritten or out-of-range locations.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  fetch address.
- fetch_ready  out  1  fetch can be accepted this cycle.
- instr_valid  out  1  instruction and instr_addr are valid.
- instruction  out  INSTR_W  fetched word.
- instr_addr  out  ADDR_W  address of the returned word.
- load_start  in  1  pulse: enter LOAD and reset the write pointer to 0.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  INSTR_W  word to write.
- load_last  in  1  marks the final load word; qualified by load_valid.
- loading  out  1  high while in LOAD.
- load_count  out  $clog2(DEPTH+1)  words written by the current or most recent load.
- instr_fault  out  1  out-of-range fetch; only meaningful with the macro.
- fault_sticky  out  1  latched fault; only meaningful with the macro.

## Operation
- There are two states: RUN (the reset state) and LOAD.
- fetch_ready = (state == RUN) && !load_start.
- A fetch is accepted when fetch_req && fetch_ready. The word at mem[fetch_addr] is registered and presented on the next cycle.
- When no fetch is accepted, instr_valid drops to 0. instruction and instr_addr hold their last values.
- Transition RUN→LOAD: on load_start. The write pointer is set to 0 and load_count is set to 0.
- In LOAD, each cycle with load_valid high:
  - mem[ptr] ← load_data;
  - ptr++;
  - load_count++.
- Transition LOAD→RUN: on the cycle after a write that carries load_last, or after the write to DEPTH-1, whichever comes first.
- load_start while already in LOAD restarts the load: ptr and load_count return to 0.
- While in LOAD, fetch_req is ignored.
- Address fetch_addr ≥ DEPTH returns NOP_VALUE.
- Memory contents power up to NOP_VALUE (initialisation, not reset). Reset never clears stored words.
- Reset values of outputs:
  - instr_valid 0;
  - instruction NOP_VALUE;
  - instr_addr 0;
  - fetch_ready 1;
  - loading 0;
  - load_count 0;
  - instr_fault 0;
  - fault_sticky 0.

## Timing
- Fetch latency is exactly 1 cycle. One fetch per cycle is sustained, so back-to-back requests produce back-to-back valid responses in order.
- A fetch accepted in the cycle before load_start is still delivered on the next cycle.
- If load_start and fetch_req are asserted in the same cycle, the load wins: the fetch is not accepted and no response is generated.
- Write-then-read: a word written in LOAD is visible to the first fetch accepted after returning to RUN.
- loading goes high the cycle after load_start. It goes low the cycle after the terminating write.
- Reset mid-load:
  - the state returns to RUN on the next cycle;
  - ptr and load_count are cleared;
  - words already written are retained.

## Configuration
- Macro: IMEM_BOUNDS_CHECK_EN.
- When defined:
  - an accepted fetch with fetch_addr ≥ DEPTH sets instr_fault = 1 alongside instr_valid;
  - fault_sticky latches 1 and holds it until reset.
- When undefined: instr_fault and fault_sticky are tied to 0. Out-of-range fetches still return NOP_VALUE.

## Structure
- Package imem_pkg holds:
  - the state enum (RUN, LOAD);
  - the default NOP_VALUE constant.
- Sub-module imem_array holds the storage: DEPTH×INSTR_W, one synchronous write port, one synchronous read port, initialised to NOP_VALUE.
- The top level holds the FSM, the write pointer, the handshake and the bounds logic.

## Test plan
- Reset, then fetch addresses 0–4 one per cycle → instr_valid high on the following 5 cycles, each instruction 0x00, instr_addr 0–4.
- load_start, then 5 words 0x11, 0x22, 0x33, 0x44, 0x55 with load_last on 0x55 → load_count 5 and loading low afterwards. Then fetch 0–4 → 0x11, 0x22, 0x33, 0x44, 0x55.
- fetch_req on 3 consecutive cycles, addresses 2, 0, 4 (after the load above) → valid on 3 consecutive cycles with 0x33, 0x11, 0x55.
- load_start and fetch_req in the same cycle → fetch_ready 0, no instr_valid next cycle, loading 1.
- rst_n low for one cycle after 2 load writes (0xAA, 0xBB) → loading 0, load_count 0, fetch_ready 1. Fetching 0 and 1 returns 0xAA and 0xBB.
- With IMEM_BOUNDS_CHECK_EN and DEPTH=200, fetch address 250 → instruction 0x00, instr_fault 1. fault_sticky stays 1 through later in-range fetches until reset.
